// File: rtl/shift_queue_ctrl_if.sv
// Enqueue/dequeue handshake bundle between the queue controller (slave) and its producer/consumer (master).
interface shift_queue_ctrl_if #(
  parameter int BITWIDTH = 1
);
  logic                enq_valid;
  logic                enq_ready;
  logic                deq_valid;
  logic                deq_ready;
  logic [BITWIDTH-1:0] deq_data;

  modport master (
    output enq_valid,
    output deq_ready,
    input  enq_ready,
    input  deq_valid,
    input  deq_data
  );

  modport slave (
    input  enq_valid,
    input  deq_ready,
    output enq_ready,
    output deq_valid,
    output deq_data
  );
endinterface

// File: rtl/shift_queue_ctrl.sv
// In-order FIFO control over a left-shift line; entry visible one cycle after push, dequeue is combinational.
// Backpressure: enq_ready drops when full unless the consumer pops the same cycle, and during/after flush.
module shift_queue_ctrl #(
  parameter int BITWIDTH   = 1,
  parameter int SHIFTERLEN = 10,
  parameter int AF_THRESH  = SHIFTERLEN - 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  shift_queue_ctrl_if.slave                    q,
  input  logic                                 flush,
  output logic                                 enShift,
  input  logic [SHIFTERLEN-1:0][BITWIDTH-1:0]  regOut,
  output logic [$clog2(SHIFTERLEN)-1:0]        head_idx,
  output logic [$clog2(SHIFTERLEN+1)-1:0]      count,
  output logic                                 full,
  output logic                                 empty,
  output logic                                 almost_full
);
  localparam int CW = $clog2(SHIFTERLEN + 1);
  localparam int IW = $clog2(SHIFTERLEN);
  localparam logic [CW-1:0] LEN_C = CW'(SHIFTERLEN);
  localparam logic [CW-1:0] AF_C  = CW'(AF_THRESH);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PARTIAL,
    S_FULL,
    S_FLUSH
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_EMPTY;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    q.enq_ready = !flush && (state != S_FLUSH) && ((state != S_FULL) || q.deq_ready);
    q.deq_valid = !flush && ((state == S_PARTIAL) || (state == S_FULL));
    push        = q.enq_valid && q.enq_ready;
    pop         = q.deq_valid && q.deq_ready;

    if (flush) begin
      state_nxt = S_FLUSH;
      count_nxt = '0;
    end else begin
      unique case (state)
        S_EMPTY: begin
          if (push) begin
            state_nxt = S_PARTIAL;
            count_nxt = ONE_C;
          end
        end
        S_PARTIAL: begin
          if (push && !pop) begin
            count_nxt = count + ONE_C;
            if (count == LEN_C - ONE_C) state_nxt = S_FULL;
          end else if (pop && !push) begin
            count_nxt = count - ONE_C;
            if (count == ONE_C) state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          // Simultaneous push+pop keeps the line full; the shift refills the head slot.
          if (pop && !push) begin
            state_nxt = S_PARTIAL;
            count_nxt = count - ONE_C;
          end
        end
        S_FLUSH: begin
          state_nxt = S_EMPTY;
          count_nxt = '0;
        end
        default: begin
          state_nxt = S_EMPTY;
          count_nxt = '0;
        end
      endcase
    end
  end

  assign enShift     = push;
  assign head_idx    = (count == '0) ? '0 : IW'(count - ONE_C);
  assign q.deq_data  = regOut[head_idx];
  assign full        = (count == LEN_C);
  assign empty       = (count == '0);
  assign almost_full = (count >= AF_C);

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset) count <= LEN_C);

endmodule

// File: tb/tb_shift_queue_ctrl.sv
// Randomized and directed bench for shift_queue_ctrl against a queue-based reference model.
module tb_shift_queue_ctrl;
  localparam int W   = 8;
  localparam int LEN = 10;
  localparam int AF  = LEN - 2;
  localparam int CW  = $clog2(LEN + 1);
  localparam int IW  = $clog2(LEN);

  logic                    clk;
  logic                    reset;
  logic                    flush;
  logic                    enShift;
  logic [LEN-1:0][W-1:0]   sreg;
  logic [W-1:0]            din;
  logic [IW-1:0]           head_idx;
  logic [CW-1:0]           count;
  logic                    full;
  logic                    empty;
  logic                    almost_full;

  shift_queue_ctrl_if #(.BITWIDTH(W)) q_if ();

  shift_queue_ctrl #(
    .BITWIDTH  (W),
    .SHIFTERLEN(LEN),
    .AF_THRESH (AF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .q          (q_if.slave),
    .flush      (flush),
    .enShift    (enShift),
    .regOut     (sreg),
    .head_idx   (head_idx),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .almost_full(almost_full)
  );

  // The controlled shift line: new data enters at 0 and ages upward.
  always @(posedge clk) begin
    if (enShift) sreg <= {sreg[LEN-2:0], din};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            nvec = 0;
  int            nerr = 0;
  logic [W-1:0]  mq[$];
  bit            blk = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model for the currently driven inputs.
  task automatic check_outs(output bit push, output bit pop);
    bit     er;
    bit     dv;
    int     sz;
    sz   = mq.size();
    er   = !flush && !blk && ((sz < LEN) || q_if.deq_ready);
    dv   = !flush && !blk && (sz > 0);
    push = q_if.enq_valid && er;
    pop  = q_if.deq_ready && dv;
    chk("enq_ready", 32'(q_if.enq_ready), 32'(er));
    chk("deq_valid", 32'(q_if.deq_valid), 32'(dv));
    chk("enShift", 32'(enShift), 32'(push));
    chk("count", 32'(count), 32'(sz));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full", 32'(full), 32'(sz == LEN));
    chk("almost_full", 32'(almost_full), 32'(sz >= AF));
    chk("head_idx", 32'(head_idx), (sz > 0) ? 32'(sz - 1) : 32'd0);
    if (sz > 0) chk("deq_data", 32'(q_if.deq_data), 32'(mq[0]));
  endtask

  task automatic step(input bit ev, input bit dr, input bit fl, input logic [W-1:0] d);
    bit push;
    bit pop;
    q_if.enq_valid = ev;
    q_if.deq_ready = dr;
    flush          = fl;
    din            = d;
    #2;
    check_outs(push, pop);
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
      blk = 1'b1;
    end else begin
      blk = 1'b0;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(d);
    end
  endtask

  task automatic fill_to(input int n);
    for (int i = 0; i < 4 * LEN && mq.size() < n; i++) step(1'b1, 1'b0, 1'b0, W'($urandom));
  endtask

  task automatic drain_to(input int n);
    for (int i = 0; i < 4 * LEN && mq.size() > n; i++) step(1'b0, 1'b1, 1'b0, W'($urandom));
  endtask

  initial begin
    bit           p;
    bit           r;
    logic [W-1:0] a_val;

    reset          = 1'b0;
    flush          = 1'b0;
    din            = '0;
    q_if.enq_valid = 1'b0;
    q_if.deq_ready = 1'b0;
    #12;
    check_outs(p, r);
    #4 reset = 1'b1;
    @(posedge clk);
    #1;

    // A, B, C with no consumer: A must be at the head, index 2.
    a_val = 8'hA1;
    step(1'b1, 1'b0, 1'b0, a_val);
    step(1'b1, 1'b0, 1'b0, 8'hB2);
    step(1'b1, 1'b0, 1'b0, 8'hC3);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("abc_head_data", 32'(q_if.deq_data), 32'(a_val));
    chk("abc_head_idx", 32'(head_idx), 32'd2);

    // Fill, stall when full, then push+pop while full.
    fill_to(LEN);
    step(1'b1, 1'b0, 1'b0, 8'h55);
    step(1'b1, 1'b1, 1'b0, 8'h66);
    step(1'b1, 1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Down to one entry, then the last pop empties it.
    drain_to(1);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);

    // Sustained push+pop at count 5.
    fill_to(5);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, W'($urandom));
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Flush with a pending enqueue.
    fill_to(6);
    step(1'b1, 1'b0, 1'b1, 8'h99);
    step(1'b1, 1'b0, 1'b0, 8'h9A);
    step(1'b1, 1'b0, 1'b0, 8'h9B);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Asynchronous reset mid-cycle at count 7.
    drain_to(0);
    fill_to(7);
    #3 reset = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_deq_valid", 32'(q_if.deq_valid), 32'd0);
    mq.delete();
    blk = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;

    // Crossing the almost-full threshold.
    fill_to(7);
    step(1'b1, 1'b0, 1'b0, 8'h42);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 31) == 0), W'($urandom));
    end
    for (int i = 0; i < 100; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'b0, W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/shift_queue_ctrl.md
# shift_queue_ctrl

Controller that turns a left-shift register line into an in-order FIFO queue for the out-of-order core. It decides when the line shifts. It tracks occupancy and exposes the oldest entry through a valid/ready dequeue port. New entries always enter at location 0 and age toward location SHIFTERLEN-1, so the oldest live entry sits at index count-1. The block sits beside the shift register: it drives the register's `enShift` and reads back the register's full `out` array.

## Interface
Parameters:
- `BITWIDTH`, 1: bits per entry; must match the controlled shift register.
- `SHIFTERLEN`, 10: number of entries; must match the controlled shift register; ≥2.
- `AF_THRESH`, SHIFTERLEN-2: `almost_full` asserts when count ≥ AF_THRESH.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `enq_valid`  in  1  producer has an entry on the shift register's `in`.
- `enq_ready`  out  1  controller accepts the entry this cycle.
- `deq_valid`  out  1  `deq_data` holds the oldest live entry.
- `deq_ready`  in  1  consumer takes the oldest entry this cycle.
- `flush`  in  1  discard all entries.
- `enShift`  out  1  drives the shift register's shift enable.
- `regOut`  in  BITWIDTH × SHIFTERLEN  the shift register's `out` array.
- `deq_data`  out  BITWIDTH  `regOut[head_idx]`.
- `head_idx`  out  $clog2(SHIFTERLEN)  index of the oldest entry.
- `count`  out  $clog2(SHIFTERLEN+1)  number of live entries.
- `full`, `empty`, `almost_full`  out  1 each  occupancy flags.

## Operation
States:
- EMPTY: count==0.
- PARTIAL: 0<count<SHIFTERLEN.
- FULL: count==SHIFTERLEN.
- FLUSH: one-cycle drain, count==0.

Handshake terms:
- push = enq_valid & enq_ready.
- pop = deq_valid & deq_ready.

Combinational outputs:
- `enq_ready` = !flush & state!=FLUSH & (state!=FULL | deq_ready). A push is allowed when FULL only if the consumer pops the same cycle; the departing entry is read before the edge.
- `deq_valid` = !flush & (state==PARTIAL | state==FULL).
- `enShift` = push. The line shifts only on a push, never on a pop alone.
- `head_idx` = count-1 when count>0, otherwise 0.
- `deq_data` = regOut[head_idx].
- `full` = (count==SHIFTERLEN); `empty` = (count==0); `almost_full` = (count≥AF_THRESH).

Count update:
- push only: count+1.
- pop only: count-1.
- push and pop together: count unchanged. The shift moves the next-oldest entry into `head_idx`.
- neither: count unchanged.

Transitions:
- EMPTY→PARTIAL on push. Pop is impossible because `deq_valid`=0, so an empty queue has no bypass.
- PARTIAL→FULL when push only and count==SHIFTERLEN-1.
- PARTIAL→EMPTY when pop only and count==1.
- FULL→PARTIAL on pop only.
- FULL stays FULL on push and pop together.
- Any state→FLUSH when `flush`=1. count←0 at that edge; the handshakes are already blocked that cycle.
- FLUSH→EMPTY after one cycle, unconditionally. A `flush` held high keeps the block in FLUSH.

Other rules:
- Register contents are never cleared by this block. Validity comes only from `count`.
- Overflow and underflow are impossible by construction. An assertion must flag count>SHIFTERLEN.

## Timing
- Reset (`reset`=0, asynchronous): state=EMPTY, count=0.
  - Outputs during and after reset with flush=0: enq_ready=1, deq_valid=0, enShift=0 (enq_valid=0), head_idx=0, deq_data=regOut[0], full=0, empty=1, almost_full=0 (AF_THRESH>0).
  - Reset mid-operation discards all entries immediately, with no completion of in-flight handshakes.
- Latency:
  - An enqueued entry is dequeue-visible the cycle after its push edge.
  - Minimum occupancy residency is one cycle.
- Throughput: one push and one pop per cycle sustained in PARTIAL and FULL.
- `enq_ready` depends combinationally on `deq_ready` and `flush`; `deq_valid` depends on `flush`. The consumer must not make `deq_ready` depend on `enq_ready`.
- Flush: 2 cycles from `flush` assertion to `enq_ready`=1 (flush cycle plus FLUSH state).

## Test plan
- Reset, then push A,B,C (enq_valid=1 for 3 cycles, deq_ready=0) → count=3, head_idx=2, deq_data=A, enShift high for exactly 3 cycles.
- Push 10 entries, SHIFTERLEN=10 → count=10, full=1, enq_ready=0 with deq_ready=0. Then raise enq_valid and deq_ready together → pop returns the oldest, count stays 10, enq_ready=1.
- Start from count=1, pop with enq_valid=0 → next cycle count=0, empty=1, deq_valid=0, state EMPTY.
- Count=5, assert push and pop together 4 cycles → count=5 throughout, popped data in enqueue order.
- Count=6, flush=1 with enq_valid=1 → enq_ready=0, enShift=0; next cycle count=0, enq_ready=0; cycle after, enq_ready=1.
- Count=7, drop `reset` low asynchronously mid-cycle → count=0, deq_valid=0 before the next edge; AF_THRESH=8 with count 7→8 → almost_full rises.
